// File: rtl/pulse_pkg.sv
// ----------------------------------------------------------------------------
// pulse_pkg: register map, bit positions and FSM encoding for pulse_fifo_reader
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pulse_pkg;

  localparam int REC_W = 64;

  localparam logic [1:0] REG_STATUS  = 2'd0;
  localparam logic [1:0] REG_DATA_LO = 2'd1;
  localparam logic [1:0] REG_DATA_HI = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  localparam int CTRL_FLUSH_BIT  = 0;
  localparam int CTRL_CLR_BIT    = 1;
  localparam int CTRL_IRQ_EN_BIT = 2;

  localparam int STAT_VALID_BIT  = 0;
  localparam int STAT_EMPTY_BIT  = 1;
  localparam int STAT_FLUSH_BIT  = 2;
  localparam int STAT_IRQ_EN_BIT = 3;
  localparam int STAT_CNT_LSB    = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_FLUSH = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pulse_fifo_reader.sv
// ----------------------------------------------------------------------------
// pulse_fifo_reader: drains 64-bit photon-count records into a 32-bit Avalon-MM slave
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pulse_fifo_reader
  import pulse_pkg::*;
#(
  parameter int FIFO_RD_LATENCY = 1,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             fifo_read,
  input  logic [REC_W-1:0] fifo_readdata,
  input  logic             fifo_empty,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  output logic [31:0]      avs_readdata,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic             irq
);

  localparam logic [1:0] LAT_INIT = 2'(FIFO_RD_LATENCY);

  state_t             state_q, state_d;
  logic [1:0]         lat_cnt_q, lat_cnt_d;
  logic               fifo_read_q, fifo_read_d;
  logic [REC_W-1:0]   rec_q, rec_d;
  logic               rec_valid_q, rec_valid_d;
  logic [CNT_W-1:0]   rec_cnt_q, rec_cnt_d;
  logic               irq_en_q, irq_en_d;
  logic               irq_q, irq_d;
  logic [31:0]        rdata_q, rdata_d;

  logic               ctrl_wr;
  logic               flush_req;
  logic               pop;
  logic [31:0]        cnt32;
  logic [31:0]        status;
  logic               wdata_unused;

  assign ctrl_wr   = avs_write && (avs_address == REG_CTRL);
  assign flush_req = ctrl_wr && avs_writedata[CTRL_FLUSH_BIT] && (state_q != S_FLUSH);
  assign pop       = avs_read && (avs_address == REG_DATA_HI) && rec_valid_q && (state_q == S_HOLD);
  assign cnt32     = 32'(rec_cnt_q);
  assign wdata_unused = ^avs_writedata[31:3];

  always_comb begin
    status = '0;
    status[STAT_VALID_BIT]  = rec_valid_q;
    status[STAT_EMPTY_BIT]  = fifo_empty;
    status[STAT_FLUSH_BIT]  = (state_q == S_FLUSH);
    status[STAT_IRQ_EN_BIT] = irq_en_q;
    status[STAT_CNT_LSB +: 16] = cnt32[15:0];
  end

  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    fifo_read_d = 1'b0;
    rec_d       = rec_q;
    rec_valid_d = rec_valid_q;
    rec_cnt_d   = rec_cnt_q;
    irq_en_d    = irq_en_q;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d     = S_REQ;
          fifo_read_d = 1'b1;
        end
      end
      S_REQ: begin
        state_d   = S_WAIT;
        lat_cnt_d = LAT_INIT;
      end
      S_WAIT: begin
        lat_cnt_d = lat_cnt_q - 2'd1;
        if (lat_cnt_q == 2'd1) begin
          rec_d       = fifo_readdata;
          rec_valid_d = 1'b1;
          rec_cnt_d   = rec_cnt_q + CNT_W'(1);
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (pop) begin
          rec_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      S_FLUSH: begin
        // One outstanding read at a time: issue, wait out its latency, drop it.
        if (fifo_read_q) begin
          lat_cnt_d = LAT_INIT;
        end else if (lat_cnt_q != 2'd0) begin
          lat_cnt_d = lat_cnt_q - 2'd1;
        end else if (fifo_empty) begin
          state_d = S_IDLE;
        end else begin
          fifo_read_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A read already in flight keeps its latency count so its data is discarded.
    if (flush_req) begin
      state_d     = S_FLUSH;
      rec_d       = rec_q;
      rec_valid_d = 1'b0;
      rec_cnt_d   = rec_cnt_q;
      fifo_read_d = 1'b0;
      if (fifo_read_q) begin
        lat_cnt_d = LAT_INIT;
      end else if (state_q == S_WAIT) begin
        lat_cnt_d = lat_cnt_q - 2'd1;
      end else begin
        lat_cnt_d = 2'd0;
      end
    end

    if (ctrl_wr) begin
      irq_en_d = avs_writedata[CTRL_IRQ_EN_BIT];
      if (avs_writedata[CTRL_CLR_BIT]) begin
        rec_cnt_d = '0;
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    irq_d   = rec_valid_q & irq_en_q;
    if (avs_read) begin
      case (avs_address)
        REG_STATUS:  rdata_d = status;
        REG_DATA_LO: rdata_d = rec_q[31:0];
        REG_DATA_HI: rdata_d = rec_q[63:32];
        default:     rdata_d = cnt32;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      lat_cnt_q   <= 2'd0;
      fifo_read_q <= 1'b0;
      rec_q       <= '0;
      rec_valid_q <= 1'b0;
      rec_cnt_q   <= '0;
      irq_en_q    <= 1'b0;
      irq_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      fifo_read_q <= fifo_read_d;
      rec_q       <= rec_d;
      rec_valid_q <= rec_valid_d;
      rec_cnt_q   <= rec_cnt_d;
      irq_en_q    <= irq_en_d;
      irq_q       <= irq_d;
      rdata_q     <= rdata_d;
    end
  end

  assign fifo_read    = fifo_read_q;
  assign avs_readdata = rdata_q;
  assign irq          = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_pulse_fifo_reader.sv
// ----------------------------------------------------------------------------
// tb_pulse_fifo_reader: directed bench for pulse_fifo_reader (latency 1 and 2 instances)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pulse_fifo_reader;
  import pulse_pkg::*;

  localparam int OP_PUSH = 0;
  localparam int OP_RD   = 1;
  localparam int OP_IDLE = 2;

  typedef struct {
    int          op;
    logic [1:0]  addr;
    logic [63:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Instance 1: FIFO_RD_LATENCY = 1
  logic        reset;
  logic        fifo_read1;
  logic [63:0] fifo_readdata1 = '0;
  logic        fifo_empty1;
  logic [1:0]  avs_address1;
  logic        avs_read1;
  logic [31:0] avs_readdata1;
  logic        avs_write1;
  logic [31:0] avs_writedata1;
  logic        irq1;

  // Instance 2: FIFO_RD_LATENCY = 2
  logic        rst2;
  logic        fifo_read2;
  logic [63:0] fifo_readdata2 = 64'hDEAD_BEEF_DEAD_BEEF;
  logic        fifo_empty2;
  logic [1:0]  avs_address2;
  logic        avs_read2;
  logic [31:0] avs_readdata2;
  logic        avs_write2;
  logic [31:0] avs_writedata2;
  logic        irq2;

  pulse_fifo_reader #(.FIFO_RD_LATENCY(1), .CNT_W(32)) dut1 (
    .clk(clk), .reset(reset), .fifo_read(fifo_read1), .fifo_readdata(fifo_readdata1),
    .fifo_empty(fifo_empty1), .avs_address(avs_address1), .avs_read(avs_read1),
    .avs_readdata(avs_readdata1), .avs_write(avs_write1), .avs_writedata(avs_writedata1),
    .irq(irq1)
  );

  pulse_fifo_reader #(.FIFO_RD_LATENCY(2), .CNT_W(32)) dut2 (
    .clk(clk), .reset(rst2), .fifo_read(fifo_read2), .fifo_readdata(fifo_readdata2),
    .fifo_empty(fifo_empty2), .avs_address(avs_address2), .avs_read(avs_read2),
    .avs_readdata(avs_readdata2), .avs_write(avs_write2), .avs_writedata(avs_writedata2),
    .irq(irq2)
  );

  // Latency-1 FIFO model for instance 1
  logic [63:0] mem1 [16];
  int wp1 = 0;
  int rp1 = 0;
  int pulses1 = 0;
  assign fifo_empty1 = (wp1 == rp1);

  always @(posedge clk) begin
    if (fifo_read1) begin
      pulses1 <= pulses1 + 1;
      if (wp1 != rp1) begin
        fifo_readdata1 <= mem1[rp1 % 16];
        rp1 <= rp1 + 1;
      end
    end
  end

  // Latency-2 never-empty source for instance 2: record n carries n in both words
  logic rd2_d1;
  int   n2 = 0;
  assign fifo_empty2 = 1'b0;

  always @(posedge clk or posedge rst2) begin
    if (rst2) begin
      rd2_d1 <= 1'b0;
    end else begin
      rd2_d1 <= fifo_read2;
      if (rd2_d1) begin
        n2 <= n2 + 1;
        fifo_readdata2 <= {32'hB000_0000 | 32'(n2 + 1), 32'hA000_0000 | 32'(n2 + 1)};
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic push1(input logic [63:0] d);
    mem1[wp1 % 16] = d;
    wp1 = wp1 + 1;
  endtask

  task automatic do_read(input int which, input logic [1:0] addr, input logic [31:0] exp,
                         input string name);
    @(posedge clk); #1;
    if (which == 1) begin
      avs_address1 = addr; avs_read1 = 1'b1;
    end else begin
      avs_address2 = addr; avs_read2 = 1'b1;
    end
    @(posedge clk); #1;
    avs_read1 = 1'b0;
    avs_read2 = 1'b0;
    check(name, (which == 1) ? avs_readdata1 : avs_readdata2, exp);
  endtask

  task automatic do_write(input logic [1:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    avs_address1 = addr; avs_writedata1 = data; avs_write1 = 1'b1;
    @(posedge clk); #1;
    avs_write1 = 1'b0;
  endtask

  vec_t tbl[$];
  int   p0;

  initial begin
    tbl.push_back('{OP_RD,   REG_DATA_LO, 64'd0, 32'h0000_00A5, "lo_rec0"});
    tbl.push_back('{OP_RD,   REG_DATA_HI, 64'd0, 32'h0000_0001, "hi_rec0"});
    tbl.push_back('{OP_RD,   REG_CTRL,    64'd0, 32'd1,         "cnt_rec0"});
    tbl.push_back('{OP_PUSH, 2'd0, 64'h1111_2222_3333_4444, 32'd0, "push_r1"});
    tbl.push_back('{OP_PUSH, 2'd0, 64'h5555_6666_7777_8888, 32'd0, "push_r2"});
    tbl.push_back('{OP_PUSH, 2'd0, 64'h9999_AAAA_BBBB_CCCC, 32'd0, "push_r3"});
    tbl.push_back('{OP_IDLE, 2'd0, 64'd6, 32'd0, "gap"});
    tbl.push_back('{OP_RD,   REG_DATA_LO, 64'd0, 32'h3333_4444, "lo_r1"});
    tbl.push_back('{OP_RD,   REG_DATA_HI, 64'd0, 32'h1111_2222, "hi_r1"});
    tbl.push_back('{OP_IDLE, 2'd0, 64'd6, 32'd0, "gap"});
    tbl.push_back('{OP_RD,   REG_DATA_LO, 64'd0, 32'h7777_8888, "lo_r2"});
    tbl.push_back('{OP_RD,   REG_DATA_HI, 64'd0, 32'h5555_6666, "hi_r2"});
    tbl.push_back('{OP_IDLE, 2'd0, 64'd6, 32'd0, "gap"});
    tbl.push_back('{OP_RD,   REG_DATA_LO, 64'd0, 32'hBBBB_CCCC, "lo_r3"});
    tbl.push_back('{OP_RD,   REG_DATA_HI, 64'd0, 32'h9999_AAAA, "hi_r3"});
    tbl.push_back('{OP_IDLE, 2'd0, 64'd6, 32'd0, "gap"});
    tbl.push_back('{OP_RD,   REG_STATUS,  64'd0, 32'h0004_0002, "status_drained"});
    tbl.push_back('{OP_RD,   REG_CTRL,    64'd0, 32'd4,         "cnt_drained"});
    tbl.push_back('{OP_RD,   REG_DATA_HI, 64'd0, 32'h9999_AAAA, "spurious_hi1"});
    tbl.push_back('{OP_RD,   REG_DATA_HI, 64'd0, 32'h9999_AAAA, "spurious_hi2"});
    tbl.push_back('{OP_IDLE, 2'd0, 64'd4, 32'd0, "gap"});
    tbl.push_back('{OP_RD,   REG_STATUS,  64'd0, 32'h0004_0002, "status_after_spurious"});

    reset = 1'b1; rst2 = 1'b1;
    avs_address1 = REG_STATUS; avs_read1 = 1'b0; avs_write1 = 1'b0; avs_writedata1 = '0;
    avs_address2 = REG_STATUS; avs_read2 = 1'b0; avs_write2 = 1'b0; avs_writedata2 = '0;
    push1(64'h0000_0001_0000_00A5);
    repeat (2) @(posedge clk);
    #1;
    check("rst_fifo_read", {31'd0, fifo_read1}, 32'd0);
    check("rst_irq", {31'd0, irq1}, 32'd0);
    check("rst_readdata", avs_readdata1, 32'd0);
    check("rst2_fifo_read", {31'd0, fifo_read2}, 32'd0);

    // Fetch latency: STATUS polled every cycle from the first IDLE sample (e0)
    avs_address1 = REG_STATUS; avs_read1 = 1'b1;
    reset = 1'b0; rst2 = 1'b0;
    @(posedge clk); #1;
    check("fetch_read_e0", {31'd0, fifo_read1}, 32'd1);
    @(posedge clk); #1;
    check("fetch_read_e1", {31'd0, fifo_read1}, 32'd0);
    check("fetch_valid_e1", {31'd0, avs_readdata1[0]}, 32'd0);
    @(posedge clk); #1;
    check("fetch_valid_e2", {31'd0, avs_readdata1[0]}, 32'd0);
    @(posedge clk); #1;
    check("fetch_valid_e3", {31'd0, avs_readdata1[0]}, 32'd1);
    avs_read1 = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      case (tbl[i].op)
        OP_PUSH: push1(tbl[i].data);
        OP_RD:   do_read(1, tbl[i].addr, tbl[i].exp, tbl[i].name);
        default: begin
          repeat (int'(tbl[i].data[7:0])) @(posedge clk);
          #1;
        end
      endcase
    end
    check("fifo_read_pulses", 32'(pulses1), 32'd4);

    // Flush with one record held and four still queued
    for (int i = 0; i < 5; i++) push1({32'h0000_0400 + 32'(i), 32'h0000_0040 + 32'(i)});
    repeat (6) @(posedge clk);
    #1;
    do_read(1, REG_DATA_LO, 32'h0000_0040, "flush_held_lo");
    do_read(1, REG_STATUS, 32'h0005_0001, "flush_pre_status");
    p0 = pulses1;
    do_write(REG_CTRL, 32'h1);
    do_read(1, REG_STATUS, 32'h0005_0004, "flush_active_status");
    repeat (20) @(posedge clk);
    #1;
    do_read(1, REG_STATUS, 32'h0005_0002, "flush_done_status");
    check("flush_pulses", 32'(pulses1 - p0), 32'd4);

    // IRQ timing and counter clear
    do_write(REG_CTRL, 32'h4);
    push1(64'hCAFE_0009_F00D_0009);
    repeat (3) @(posedge clk);
    #1;
    check("irq_at_capture", {31'd0, irq1}, 32'd0);
    @(posedge clk); #1;
    check("irq_high", {31'd0, irq1}, 32'd1);
    do_read(1, REG_DATA_HI, 32'hCAFE_0009, "irq_rec_hi");
    check("irq_at_pop", {31'd0, irq1}, 32'd1);
    @(posedge clk); #1;
    check("irq_drop", {31'd0, irq1}, 32'd0);
    do_read(1, REG_CTRL, 32'd6, "cnt_before_clear");
    do_write(REG_CTRL, 32'h6);
    do_read(1, REG_CTRL, 32'd0, "cnt_cleared");
    do_read(1, REG_STATUS, 32'h0000_000A, "status_irq_en");

    // Clear lands on the same edge as a capture
    push1(64'hBEEF_0010_0000_0010);
    @(posedge clk);
    do_write(REG_CTRL, 32'h6);
    do_read(1, REG_CTRL, 32'd0, "clr_beats_capture");
    check("irq_after_clr", {31'd0, irq1}, 32'd1);
    do_read(1, REG_DATA_HI, 32'hBEEF_0010, "clr_rec_hi");

    // Latency-2 instance: capture timing, then reset while a read is in flight
    do_read(2, REG_DATA_LO, 32'hA000_0001, "l2_lo_rec1");
    do_read(2, REG_DATA_HI, 32'hB000_0001, "l2_hi_rec1");
    @(posedge clk); #1;
    check("l2_req", {31'd0, fifo_read2}, 32'd1);
    @(posedge clk); #1;
    check("l2_req_end", {31'd0, fifo_read2}, 32'd0);
    @(posedge clk); #2;
    rst2 = 1'b1;
    #1;
    check("async_rst_readdata", avs_readdata2, 32'd0);
    check("async_rst_fifo_read", {31'd0, fifo_read2}, 32'd0);
    check("async_rst_irq", {31'd0, irq2}, 32'd0);
    @(posedge clk); #1;
    rst2 = 1'b0;
    @(posedge clk); #1;
    check("restart_req", {31'd0, fifo_read2}, 32'd1);
    repeat (6) @(posedge clk);
    #1;
    do_read(2, REG_DATA_LO, 32'hA000_0003, "restart_lo");
    do_read(2, REG_CTRL, 32'd1, "restart_cnt");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
